// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared constants and types for the 1-to-2 stream demux.
//               Macro STREAM_DEMUX_SKID_EN selects the 2-entry skid slot.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    // Default data width of the input and both outputs
    localparam int DEF_WIDTH = 64;

    // Destination select encoding
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_sel_e;

    // Per-output slot depth; the skid build decouples in_ready from outN_ready
`ifdef STREAM_DEMUX_SKID_EN
    localparam int SLOT_DEPTH = 2;
`else
    localparam int SLOT_DEPTH = 1;
`endif

endpackage
`default_nettype wire

// File: rtl/stream_demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_slot
// Description : One output buffer (1 or 2 entries) with valid/ready drain.
//               Depth follows SLOT_DEPTH, set by STREAM_DEMUX_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = SLOT_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    generate
        if (DEPTH == 1) begin : g_depth1
            logic             r_valid;
            logic [WIDTH-1:0] r_data;

            // Single slot: fill has priority, so drain+fill keeps it FULL with the new word
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (i_fill) begin
                    r_valid <= 1'b1;
                    r_data  <= i_data;
                end else if (r_valid && i_ready) begin
                    r_valid <= 1'b0;
                end
            end

            assign o_valid = r_valid;
            assign o_data  = r_data;
            assign o_full  = r_valid;
        end else begin : g_depth2
            logic [WIDTH-1:0] r_mem0;   // head entry, drives the output
            logic [WIDTH-1:0] r_mem1;   // second entry
            logic [1:0]       r_count;
            logic             w_pop;

            assign w_pop = (r_count != 2'd0) && i_ready;

            // Two-entry shift FIFO; head always sits in r_mem0
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_mem0  <= '0;
                    r_mem1  <= '0;
                    r_count <= 2'd0;
                end else begin
                    case (r_count)
                        2'd0: begin
                            if (i_fill) begin
                                r_mem0  <= i_data;
                                r_count <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (i_fill && w_pop) begin
                                r_mem0 <= i_data;
                            end else if (i_fill) begin
                                r_mem1  <= i_data;
                                r_count <= 2'd2;
                            end else if (w_pop) begin
                                r_count <= 2'd0;
                            end
                        end
                        2'd2: begin
                            if (w_pop) begin
                                r_mem0 <= r_mem1;
                                if (i_fill) begin
                                    r_mem1 <= i_data;
                                end else begin
                                    r_count <= 2'd1;
                                end
                            end
                        end
                        default: r_count <= 2'd0;
                    endcase
                end
            end

            assign o_valid = (r_count != 2'd0);
            assign o_data  = r_mem0;
            assign o_full  = (r_count == 2'd2);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1to2
// Description : Routes a valid/ready stream to one of two outputs by in_sel,
//               one cycle latency, independent per-port buffering.
//               Define STREAM_DEMUX_SKID_EN for the registered-ready skid build.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1to2
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
);

    port_sel_e w_sel;
    logic      w_full0;
    logic      w_full1;
    logic      w_sel_full;
    logic      w_sel_ready;
    logic      w_accept;
    logic      w_fill0;
    logic      w_fill1;

    assign w_sel       = port_sel_e'(in_sel);
    assign w_sel_full  = (w_sel == PORT1) ? w_full1    : w_full0;
    assign w_sel_ready = (w_sel == PORT1) ? out1_ready : out0_ready;

`ifdef STREAM_DEMUX_SKID_EN
    // Ready comes from registered slot state only; the spare entry absorbs a stall
    assign in_ready = reset_n && !w_sel_full;
`else
    // A full slot can still accept when it drains in the same cycle
    assign in_ready = reset_n && (!w_sel_full || w_sel_ready);
`endif

    // in_valid gates everything, so unknown sel/data while idle never reaches state
    assign w_accept = in_valid && in_ready;
    assign w_fill0  = w_accept && (w_sel == PORT0);
    assign w_fill1  = w_accept && (w_sel == PORT1);

    stream_demux_slot #(
        .WIDTH (WIDTH),
        .DEPTH (SLOT_DEPTH)
    ) u_slot0 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_fill  (w_fill0),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_data  (out0_data),
        .o_full  (w_full0)
    );

    stream_demux_slot #(
        .WIDTH (WIDTH),
        .DEPTH (SLOT_DEPTH)
    ) u_slot1 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_fill  (w_fill1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_data  (out1_data),
        .o_full  (w_full1)
    );

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1to2
// Description : Self-checking bench for stream_demux_1to2 with per-port
//               scoreboards. Honours STREAM_DEMUX_SKID_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1to2;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               n_vec;
    int               n_err;

    stream_demux_1to2 #(.WIDTH(WIDTH)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it on mismatch
    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; check in_ready at mid-cycle, record it if accepted.
    // chk_port >= 0 also checks that this port shows a valid word now.
    task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic exp_rdy, input int chk_port);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        @(negedge clk);
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (chk_port == 0) chk("b2b_v0", {63'd0, out0_valid}, 64'd1);
        if (chk_port == 1) chk("b2b_v1", {63'd0, out1_valid}, 64'd1);
        if (in_ready) begin
            if (s) q1.push_back(d);
            else   q0.push_back(d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Output monitor: every output transfer must match the scoreboard head
    always @(negedge clk) begin
        if (reset_n) begin
            if (out0_valid && out0_ready) begin
                if (q0.size() == 0) chk("out0_unexp", out0_data, '0 - 1);
                else                chk("out0_data", out0_data, q0.pop_front());
            end
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) chk("out1_unexp", out1_data, '0 - 1);
                else                chk("out1_data", out1_data, q1.pop_front());
            end
        end
    end

    // Assert reset for one edge, then check the cleared outputs
    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_v0", {63'd0, out0_valid}, 64'd0);
        chk("rst_v1", {63'd0, out1_valid}, 64'd0);
        chk("rst_d0", out0_data, 64'd0);
        chk("rst_d1", out1_data, 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        do_reset();

        // Single route to port 1
        send(64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1, -1);
        @(negedge clk);
        chk("single_v1", {63'd0, out1_valid}, 64'd1);
        chk("single_v0", {63'd0, out0_valid}, 64'd0);
        tick();
        chk("single_q1", q1.size(), 64'd0);

        // Back-to-back alternating stream, both sinks ready
        for (int i = 1; i <= 8; i++) begin
            send(64'(i), 1'((i - 1) % 2), 1'b1, (i > 1) ? ((i - 2) % 2) : -1);
        end
        tick();
        tick();
        chk("b2b_q0", q0.size(), 64'd0);
        chk("b2b_q1", q1.size(), 64'd0);

        // Stall isolation: port 0 blocked holding 0xA0
        out0_ready = 1'b0;
        send(64'hA0, 1'b0, 1'b1, -1);
        send(64'hB1, 1'b1, 1'b1, 0);
        @(negedge clk);
        chk("stall_v1", {63'd0, out1_valid}, 64'd1);
        tick();
`ifdef STREAM_DEMUX_SKID_EN
        send(64'hA2, 1'b0, 1'b1, 0);
        send(64'hA3, 1'b0, 1'b0, 0);
`else
        send(64'hA2, 1'b0, 1'b0, 0);
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold_v0", {63'd0, out0_valid}, 64'd1);
            chk("stall_hold_d0", out0_data, 64'hA0);
            tick();
        end
        out0_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("stall_q0", q0.size(), 64'd0);
        chk("stall_q1", q1.size(), 64'd0);

        // Simultaneous drain and fill on port 0
        out0_ready = 1'b0;
        send(64'h11, 1'b0, 1'b1, -1);
        out0_ready = 1'b1;
        send(64'h22, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("df_v0", {63'd0, out0_valid}, 64'd1);
        chk("df_d0", out0_data, 64'h22);
        tick();
        tick();
        chk("df_q0", q0.size(), 64'd0);

        // Mid-stream reset with both slots holding a word
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(64'h33, 1'b0, 1'b1, -1);
        send(64'h44, 1'b1, 1'b1, -1);
        do_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("postrst_v0", {63'd0, out0_valid}, 64'd0);
            chk("postrst_v1", {63'd0, out1_valid}, 64'd0);
            tick();
        end

        // Unknown sel/data while idle must not disturb a held word
        out1_ready = 1'b0;
        send(64'h55, 1'b1, 1'b1, -1);
        in_sel  = 1'bx;
        in_data = 'x;
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk);
        chk("x_v0", {63'd0, out0_valid}, 64'd0);
        chk("x_v1", {63'd0, out1_valid}, 64'd1);
        chk("x_d1", out1_data, 64'h55);
        chk("x_known", {62'd0, $isunknown(out0_valid), $isunknown(out1_data)}, 64'd0);
        tick();
        in_sel     = 1'b0;
        in_data    = '0;
        out1_ready = 1'b1;
        tick();
        tick();
        chk("x_q1", q1.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
